// File: rtl/clm_inv_sequencer_pkg.sv
// rtl/clm_inv_sequencer_pkg.sv - shared types and constants for the masked GF(2^8) inverse sequencer
package clm_inv_sequencer_pkg;

   localparam int CLM_D     = 2;
   localparam int CLM_W     = 8 + CLM_D;
   localparam int INV_STEPS = 11;
   localparam int NUM_REGS  = 6;
   localparam int STEP_W    = $clog2(INV_STEPS);
   localparam int TMO_LIMIT = 12 + CLM_D;
   localparam int TMO_W     = $clog2(16 + CLM_D);

   typedef logic [CLM_W-1:0]  state_t;
   typedef logic [STEP_W-1:0] step_t;
   typedef logic [TMO_W-1:0]  tmo_t;

   typedef enum logic [2:0] {
      X   = 3'd0,
      X2  = 3'd1,
      X3  = 3'd2,
      X12 = 3'd3,
      X14 = 3'd4,
      ACC = 3'd5
   } inv_reg_e;

   typedef struct packed {
      inv_reg_e a;
      inv_reg_e b;
      inv_reg_e dst;
   } inv_step_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/clm_inv_chain_rom.sv
// rtl/clm_inv_chain_rom.sv - addition chain for x^254, one multiplication per step
module clm_inv_chain_rom
   import clm_inv_sequencer_pkg::*;
(
   input  logic [STEP_W-1:0] step_i,
   output inv_step_t         op_o
);

   // Steps 6..9 are the four squarings of ACC, covered by the default entry.
   always_comb begin
      op_o = '{a: ACC, b: ACC, dst: ACC};
      case (step_i)
         4'd0:    op_o = '{a: X,   b: X,   dst: X2};
         4'd1:    op_o = '{a: X2,  b: X,   dst: X3};
         4'd2:    op_o = '{a: X3,  b: X3,  dst: ACC};
         4'd3:    op_o = '{a: ACC, b: ACC, dst: X12};
         4'd4:    op_o = '{a: X12, b: X2,  dst: X14};
         4'd5:    op_o = '{a: X12, b: X3,  dst: ACC};
         4'd10:   op_o = '{a: ACC, b: X14, dst: ACC};
         default: op_o = '{a: ACC, b: ACC, dst: ACC};
      endcase
   end

endmodule

// File: rtl/clm_inv_sequencer.sv
// rtl/clm_inv_sequencer.sv - masked GF(2^8) inverse sequencer driving one serial CLM multiplier
// Optional WAIT timeout reported on err_o: define CLM_SEQ_TIMEOUT_EN.
module clm_inv_sequencer
   import clm_inv_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [CLM_W-1:0] x_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CLM_W-1:0] y_o,
   output logic             mul_drdy_i,
   output logic [CLM_W-1:0] mul_p1,
   output logic [CLM_W-1:0] mul_p2,
   input  logic             mul_drdy_o,
   input  logic [CLM_W-1:0] mul_out,
   output logic             err_o
);

   seq_state_e state_q, state_d;
   step_t      step_q, step_d;
   state_t     rf_q [NUM_REGS];
   state_t     rf_d [NUM_REGS];
   state_t     y_q, y_d;
   logic       done_q, done_d;
   logic       busy_q, busy_d;
   logic       first_q, first_d;
   inv_step_t  op;
   logic       last_step;
   logic       capture;
   logic       timeout;

   clm_inv_chain_rom u_rom (
      .step_i (step_q),
      .op_o   (op)
   );

   assign last_step = (step_q == step_t'(INV_STEPS - 1));
   // mul_drdy_o may still be high from the previous product in the first WAIT cycle.
   assign capture   = (state_q == WAIT) && !first_q && mul_drdy_o;

`ifdef CLM_SEQ_TIMEOUT_EN
   tmo_t cnt_q, cnt_d;
   logic err_q, err_d;

   assign timeout = (state_q == WAIT) && !capture && (cnt_q == tmo_t'(TMO_LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == ISSUE) begin
         cnt_d = tmo_t'(1);
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
      if ((state_q == IDLE) && start_i) begin
         err_d = 1'b0;
      end
      if (timeout) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      rf_d       = rf_q;
      y_d        = y_q;
      done_d     = 1'b0;
      first_d    = 1'b0;
      busy_d     = (state_q == ISSUE) || (state_q == WAIT);
      mul_drdy_i = 1'b0;
      mul_p1     = '0;
      mul_p2     = '0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               rf_d[X] = x_i;
               step_d  = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            mul_drdy_i = 1'b1;
            mul_p1     = rf_q[op.a];
            mul_p2     = rf_q[op.b];
            first_d    = 1'b1;
            state_d    = WAIT;
         end
         WAIT: begin
            if (capture) begin
               rf_d[op.dst] = mul_out;
               if (last_step) begin
                  state_d = DONE;
               end else begin
                  step_d  = step_q + 1'b1;
                  state_d = ISSUE;
               end
            end else if (timeout) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         DONE: begin
            y_d     = rf_q[ACC];
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         step_q  <= '0;
         rf_q    <= '{default: '0};
         y_q     <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         rf_q    <= rf_d;
         y_q     <= y_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         first_q <= first_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign y_o    = y_q;

endmodule

// File: tb/tb_clm_inv_sequencer.sv
// tb/tb_clm_inv_sequencer.sv - bench for clm_inv_sequencer against a GF(2^8) reference with a modelled CLM multiplier
module tb_clm_inv_sequencer;

   localparam int D        = 2;
   localparam int W        = 8 + D;
   localparam int LAT_REAL = 11 * (10 + D) + 1;
   localparam int LAT_STUB = 11 * 3 + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start_i = 1'b0;
   logic [W-1:0] x_i = '0;
   logic         busy_o, done_o, mul_drdy_i, err_o;
   logic [W-1:0] y_o, mul_p1, mul_p2;
   logic         mul_drdy_o = 1'b0;
   logic [W-1:0] mul_out = '0;

   int n_cmp = 0;
   int n_err = 0;

   // 0: latency 9+d, 1: drdy_o stuck high, 2: never answers
   int         mul_mode = 0;
   int         mul_lat  = 0;
   int         op_count = 0;
   logic [7:0] cur_x    = 8'h00;

   // Exponents of x carried by each operand at each multiplication (x^254 chain)
   int exp_a [11] = '{1, 2, 3, 6, 12, 12, 15, 30, 60, 120, 240};
   int exp_b [11] = '{1, 1, 3, 6, 2, 3, 15, 30, 60, 120, 14};

   clm_inv_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .x_i        (x_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .y_o        (y_o),
      .mul_drdy_i (mul_drdy_i),
      .mul_p1     (mul_p1),
      .mul_p2     (mul_p2),
      .mul_drdy_o (mul_drdy_o),
      .mul_out    (mul_out),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pmod(input logic [19:0] v);
      logic [19:0] t;
      t = v;
      for (int i = 19; i >= 8; i--) begin
         if (t[i]) t = t ^ (20'h11B << (i - 8));
      end
      return t[7:0];
   endfunction

   function automatic logic [19:0] clmul(input logic [9:0] a, input logic [9:0] b);
      logic [19:0] p;
      p = '0;
      for (int i = 0; i < 10; i++) begin
         if (b[i]) p = p ^ ({10'b0, a} << i);
      end
      return p;
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      return pmod(clmul({2'b0, a}, {2'b0, b}));
   endfunction

   function automatic logic [7:0] gpow(input logic [7:0] x, input int e);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < e; i++) r = gmul(r, x);
      return r;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      logic [7:0] r;
      r = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) r = 8'(y);
      end
      return r;
   endfunction

   function automatic logic [W-1:0] enc(input logic [7:0] v);
      logic [1:0]   r;
      logic [W-1:0] m;
      r = 2'($urandom_range(0, 3));
      m = {2'b0, v};
      if (r[0]) m = m ^ 10'h11B;
      if (r[1]) m = m ^ 10'h236;
      return m;
   endfunction

   function automatic logic [7:0] dec(input logic [W-1:0] v);
      return pmod({10'b0, v});
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Multiplier model: answers with a freshly re-masked product of the decoded operands.
   always @(negedge clk) begin
      if (mul_drdy_i === 1'b1) begin
         if (op_count < 11) begin
            check("op_a", dec(mul_p1), gpow(cur_x, exp_a[op_count]));
            check("op_b", dec(mul_p2), gpow(cur_x, exp_b[op_count]));
         end
         op_count++;
         mul_lat = 0;
         mul_out = enc(gmul(dec(mul_p1), dec(mul_p2)));
         mul_drdy_o = (mul_mode == 1);
      end else begin
         mul_lat++;
         if (mul_mode == 0 && mul_lat == 9 + D) mul_drdy_o = 1'b1;
         if (mul_mode == 1) mul_drdy_o = 1'b1;
      end
   end

   task automatic run_op(input logic [7:0] v, input int exp_lat, input bit hold);
      int lat;
      int busy_bad;
      @(negedge clk);
      cur_x    = v;
      op_count = 0;
      x_i      = enc(v);
      start_i  = 1'b1;
      @(posedge clk); #1;
      if (!hold) start_i = 1'b0;
      lat      = 0;
      busy_bad = (busy_o !== 1'b0) ? 1 : 0;
      check("err_clear", err_o, 0);
      while (done_o !== 1'b1 && lat < exp_lat + 20) begin
         @(posedge clk); #1;
         lat++;
         if (busy_o !== !done_o) busy_bad++;
      end
      start_i = 1'b0;
      check("latency", lat, exp_lat);
      check("y", dec(y_o), ginv(v));
      check("busy", busy_bad, 0);
      check("mul_pulses", op_count, 11);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] y_hold;
      int           extra;
      int           n;
      bit           done_seen;

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_y", y_o, 0);
      check("rst_drdy", mul_drdy_i, 0);
      check("rst_p1", mul_p1, 0);
      check("rst_p2", mul_p2, 0);
      check("rst_err", err_o, 0);
      @(negedge clk);
      rst = 1'b1;

      run_op(8'h53, LAT_REAL, 1'b0);
      check("y_53", dec(y_o), 8'hCA);
      y_hold = y_o;
      @(posedge clk); #1;
      check("done_pulse", done_o, 0);
      check("y_hold", y_o, y_hold);

      run_op(8'h01, LAT_REAL, 1'b0);
      check("y_01", dec(y_o), 8'h01);
      run_op(8'h00, LAT_REAL, 1'b0);
      check("y_00", dec(y_o), 8'h00);

      for (int v = 0; v < 256; v++) run_op(8'(v), LAT_REAL, 1'b0);
      for (int k = 0; k < 6; k++) run_op(8'($urandom_range(0, 255)), LAT_REAL, 1'b0);

      run_op(8'h53, LAT_REAL, 1'b1);
      extra = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done_o === 1'b1) extra++;
      end
      check("hold_extra_done", extra, 0);
      check("hold_pulses", op_count, 11);

      @(negedge clk);
      cur_x    = 8'h53;
      op_count = 0;
      x_i      = enc(8'h53);
      start_i  = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (49) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_busy", busy_o, 0);
      check("mid_rst_done", done_o, 0);
      check("mid_rst_y", y_o, 0);
      check("mid_rst_drdy", mul_drdy_i, 0);
      check("mid_rst_p1", mul_p1, 0);
      check("mid_rst_p2", mul_p2, 0);
      check("mid_rst_err", err_o, 0);
      @(negedge clk);
      rst = 1'b1;
      run_op(8'h53, LAT_REAL, 1'b0);
      check("y_53_after_rst", dec(y_o), 8'hCA);

      mul_mode = 1;
      run_op(8'h53, LAT_STUB, 1'b0);
      check("stub_y_53", dec(y_o), 8'hCA);
      for (int k = 0; k < 3; k++) run_op(8'($urandom_range(0, 255)), LAT_STUB, 1'b0);
      mul_mode = 0;
      repeat (3) @(posedge clk);

`ifdef CLM_SEQ_TIMEOUT_EN
      mul_mode = 2;
      @(negedge clk);
      mul_drdy_o = 1'b0;
      cur_x    = 8'h53;
      op_count = 0;
      x_i      = enc(8'h53);
      start_i  = 1'b1;
      @(posedge clk); #1;
      start_i   = 1'b0;
      n         = 0;
      done_seen = 1'b0;
      while (err_o !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done_o === 1'b1) done_seen = 1'b1;
      end
      check("tmo_cycles", n, 14);
      repeat (5) begin
         @(posedge clk); #1;
         if (done_o === 1'b1) done_seen = 1'b1;
      end
      check("tmo_no_done", done_seen, 0);
      check("tmo_err_held", err_o, 1);
      mul_mode = 0;
      run_op(8'h53, LAT_REAL, 1'b0);
      check("tmo_recover_y", dec(y_o), 8'hCA);
`else
      n         = 0;
      done_seen = 1'b0;
`endif
      check("err_final", err_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/clm_inv_sequencer.md
Name: clm_inv_sequencer

Overview:
- Initiator for the serial CLM multiplier. It computes the masked GF(2^8) inverse y = x^254 by issuing 11 multiplications over the multiplier handshake (p1/p2/drdy_i out, out/drdy_o in).
- Sits between the S-box datapath and one multiplier instance. The multiplier receives its random_vect, MC and B_ext directly; this block never touches randomness.
- All operands and results stay in the redundant (8+d)-bit CLM domain. No unmasked value is ever formed.

Parameters:
- d, 2, CLM redundancy; every state_t operand is 8+d bits wide.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- start_i  in  1  one-cycle request; sampled only in IDLE
- x_i  in  8+d  masked input; captured when start_i is accepted
- busy_o  out  1  high from the cycle after acceptance until done_o
- done_o  out  1  one-cycle pulse; y_o is valid while done_o is high and holds until the next acceptance
- y_o  out  8+d  masked x^254
- mul_drdy_i  out  1  one-cycle start pulse to the multiplier
- mul_p1  out  8+d  multiplier operand 1
- mul_p2  out  8+d  multiplier operand 2
- mul_drdy_o  in  1  multiplier result ready (level)
- mul_out  in  8+d  multiplier result
- err_o  out  1  timeout flag (only with CLM_SEQ_TIMEOUT_EN; otherwise tied 0)

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE, step=0. All register-file entries, y_o, busy_o, done_o, mul_drdy_i, mul_p1, mul_p2 and err_o are 0.
- Register file: X, X2, X3, X12, X14, ACC.
- Chain (step: dst = a*b):
  - 0: X2 = X*X
  - 1: X3 = X2*X
  - 2: ACC = X3*X3
  - 3: X12 = ACC*ACC
  - 4: X14 = X12*X2
  - 5: ACC = X12*X3
  - 6–9: ACC = ACC*ACC
  - 10: ACC = ACC*X14
- States and transitions:
  - IDLE: on start_i, X <= x_i, step <= 0, go to ISSUE.
  - ISSUE: mul_drdy_i=1 with mul_p1/mul_p2 = reg[a]/reg[b] of the current step; go to WAIT.
  - WAIT: mul_drdy_o is ignored in the first WAIT cycle, because it can still be high from the previous operation. From the second WAIT cycle on, mul_drdy_o==1 writes reg[dst] <= mul_out. Then:
    - if step==10: go to DONE;
    - otherwise step++ and go to ISSUE.
  - DONE: done_o=1, y_o <= ACC (y_o registered), go to IDLE.
- mul_p1/mul_p2 are driven to 0 outside ISSUE, so no stale shares are left on the bus.
- Latency: each operation takes 1 ISSUE cycle plus 9+d WAIT cycles (10+d total). done_o is high exactly 11*(10+d)+1 cycles after the accepting edge. For d=2 that is 133.
- start_i while busy: ignored, no queueing.
- Reset mid-operation: immediate return to IDLE with reset values. The multiplier is not reset by this block; the next ISSUE restarts it.
- x_i = 0: no special case; the chain yields masked 0.
- mul_drdy_o asserted in ISSUE: ignored.

Optional Feature:
- CLM_SEQ_TIMEOUT_EN defined:
  - A WAIT cycle counter of width clog2(16+d) is added.
  - If it reaches 12+d without a result, the block sets err_o=1, goes to IDLE without pulsing done_o, and leaves the register file untouched.
  - err_o stays high until the next accepted start_i or reset.
- CLM_SEQ_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; err_o is tied 0.

Decomposition:
- Shared package types: reuse state_t.
- Add to types:
  - inv_reg_e {X, X2, X3, X12, X14, ACC};
  - inv_step_t {inv_reg_e a, b, dst};
  - localparam INV_STEPS = 11;
  - seq_state_e {IDLE, ISSUE, WAIT, DONE}.
- One sub-module, clm_inv_chain_rom: combinational, step in, inv_step_t out. It holds the chain table so that alternative chains can be swapped in.

Test Plan:
- Pair with the real multiplier at d=2 and random random_vect. Start with the encoding of 0x53 → decoded y_o = 0xCA, done_o exactly 133 cycles after acceptance.
- x = enc(0x01) → decoded 0x01. x = enc(0x00) → decoded 0x00. Sweep all 256 values → each matches the GF(2^8) inverse (AES polynomial 0x11B).
- Hold start_i high through a whole operation → exactly one done_o pulse. busy_o is high cycles 1..132, and only 11 mul_drdy_i pulses occur.
- Drop rst low at cycle 50 → next cycle all outputs are 0 and state is IDLE. A fresh start with 0x53 then still yields 0xCA.
- Stub multiplier that holds mul_drdy_o=1 permanently → the first WAIT cycle is ignored, so capture happens in the second WAIT cycle and each operation takes 3 cycles. done_o is at cycle 34, and the per-step capture order matches the chain.
- With CLM_SEQ_TIMEOUT_EN and mul_drdy_o tied 0 → err_o rises 14 cycles after the first mul_drdy_i, done_o never pulses, and err_o clears on the next start_i.
